// File: rtl/lcd_rx_monitor.sv
// Receive-side monitor for a DE-only framed RGB888 LCD stream: rebuilds pixel
// coordinates, measures frame geometry, captures a probe pixel and flags timing errors.
module lcd_rx_monitor #(
  parameter int H_DISP_EXP  = 800,
  parameter int V_DISP_EXP  = 480,
  parameter int VBLANK_MIN  = 256,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        lcd_pclk,
  input  logic        rst_n,
  input  logic        lcd_de,
  input  logic [23:0] lcd_rgb,
  input  logic [10:0] probe_x,
  input  logic [10:0] probe_y,
  input  logic        clr_err,
  output logic        rx_valid,
  output logic [10:0] rx_xpos,
  output logic [10:0] rx_ypos,
  output logic [23:0] rx_data,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic [10:0] meas_h_disp,
  output logic [10:0] meas_v_disp,
  output logic [23:0] probe_rgb,
  output logic        probe_valid,
  output logic        err_line,
  output logic        err_frame,
  output logic        locked
);

  localparam int IW = $clog2(VBLANK_MIN + 1);
  localparam int GW = $clog2(LOCK_FRAMES + 1);

  typedef enum logic [1:0] {SEARCH, VBLANK, LINE, HBLANK} state_t;

  state_t        state;
  logic [IW-1:0] idle_cnt;
  logic [GW-1:0] good_cnt;
  logic [10:0]   x;
  logic [10:0]   y;
  logic [10:0]   line_ref;

  logic          idle_full;
  logic          x_max;
  logic [10:0]   line_len;
  logic [10:0]   y_inc;
  logic          size_ok;
  logic          frame_end;
  logic          pix;
  logic [10:0]   col;
  logic [10:0]   row;
  logic          set_line;
  logic          set_frame;
  logic [GW-1:0] good_nxt;

  assign idle_full = (idle_cnt == IW'(VBLANK_MIN));
  assign x_max     = (x == 11'd2047);
  assign line_len  = x + 11'd1;
  assign y_inc     = y + 11'd1;
  assign size_ok   = (line_ref == 11'(H_DISP_EXP)) && (y_inc == 11'(V_DISP_EXP));
  assign set_frame = frame_end && !size_ok;
  assign good_nxt  = (good_cnt == GW'(LOCK_FRAMES)) ? good_cnt : good_cnt + 1'b1;

  // Coordinate of the pixel accepted this cycle, plus end-of-line/frame events.
  always_comb begin
    frame_end = 1'b0;
    pix       = 1'b0;
    col       = x;
    row       = y;
    set_line  = 1'b0;
    case (state)
      VBLANK: begin
        if (lcd_de) begin
          pix = 1'b1;
          col = 11'd0;
          row = 11'd0;
        end
      end
      LINE: begin
        if (lcd_de) begin
          pix      = 1'b1;
          col      = x_max ? x : line_len;
          set_line = x_max;
        end else begin
          set_line = (y != 11'd0) && (line_len != line_ref);
        end
      end
      HBLANK: begin
        frame_end = idle_full;
        if (lcd_de) begin
          pix = 1'b1;
          col = 11'd0;
          row = idle_full ? 11'd0 : y_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SEARCH;
      idle_cnt    <= '0;
      good_cnt    <= '0;
      x           <= '0;
      y           <= '0;
      line_ref    <= '0;
      rx_valid    <= 1'b0;
      rx_xpos     <= '0;
      rx_ypos     <= '0;
      rx_data     <= '0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
      meas_h_disp <= '0;
      meas_v_disp <= '0;
      probe_rgb   <= '0;
      probe_valid <= 1'b0;
      err_line    <= 1'b0;
      err_frame   <= 1'b0;
      locked      <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      idle_cnt   <= lcd_de ? '0 : (idle_full ? idle_cnt : idle_cnt + 1'b1);
      rx_valid   <= pix;
      if (pix) begin
        x       <= col;
        y       <= row;
        rx_xpos <= col;
        rx_ypos <= row;
        rx_data <= lcd_rgb;
      end
      // Probe compares against the registered pixel, so capture trails it by one cycle.
      if (rx_valid && rx_xpos == probe_x && rx_ypos == probe_y) begin
        probe_rgb   <= rx_data;
        probe_valid <= 1'b1;
      end
      err_line  <= set_line  | (err_line  & ~clr_err);
      err_frame <= set_frame | (err_frame & ~clr_err);
      case (state)
        SEARCH: if (idle_full) state <= VBLANK;
        VBLANK: if (lcd_de) state <= LINE;
        LINE: begin
          if (!lcd_de) begin
            state <= HBLANK;
            if (y == 11'd0) line_ref <= line_len;
          end
        end
        HBLANK: begin
          if (lcd_de)         state <= LINE;
          else if (idle_full) state <= VBLANK;
        end
        default: state <= SEARCH;
      endcase
      if (frame_end) begin
        frame_done  <= 1'b1;
        frame_cnt   <= frame_cnt + 16'd1;
        meas_h_disp <= line_ref;
        meas_v_disp <= y_inc;
        if (size_ok) begin
          good_cnt <= good_nxt;
          locked   <= (good_nxt == GW'(LOCK_FRAMES));
        end else begin
          good_cnt <= '0;
          locked   <= 1'b0;
        end
      end
    end
  end

endmodule
